// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter/sequencer for a shared 8:1 single-bit mux.
// Grants one requester at a time, drives the mux select and captures the mux output.
module mux8_rr_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       mux_f,
    output logic [2:0] sel,
    output logic [7:0] grant,
    output logic       busy,
    output logic       data_out,
    output logic       data_valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state;
    logic [2:0]       ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic [2:0]       winner;
    logic             owner_req;
    logic             contention;
    logic             at_limit;

    // First set request bit scanning upward from p, wrapping modulo 8.
    function automatic logic [2:0] pick_winner(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        logic [2:0] win;
        win = p;
        for (int i = 7; i >= 0; i--) begin
            idx = p + 3'(i);
            if (r[idx]) win = idx;
        end
        return win;
    endfunction

    assign winner     = pick_winner(req, ptr);
    assign owner_req  = |(req & grant);
    assign contention = |(req & ~grant);
    assign at_limit   = (hold_cnt == CNT_W'(MAX_HOLD));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 8'd0;
            sel        <= 3'd0;
            busy       <= 1'b0;
            data_out   <= 1'b0;
            data_valid <= 1'b0;
            ptr        <= 3'd0;
            hold_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    data_valid <= 1'b0;
                    if (req != 8'd0) begin
                        state    <= GRANT;
                        grant    <= 8'd1 << winner;
                        sel      <= winner;
                        busy     <= 1'b1;
                        hold_cnt <= CNT_W'(1);
                    end
                end
                GRANT: begin
                    data_out   <= mux_f;
                    data_valid <= 1'b1;
                    // Release or timeout both leave one idle guard cycle before the next grant.
                    if (!owner_req || (at_limit && contention)) begin
                        state <= IDLE;
                        grant <= 8'd0;
                        busy  <= 1'b0;
                        ptr   <= sel + 3'd1;
                    end else if (!at_limit) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 8'd0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
